// File: rtl/apb_pkg.sv
// APB master shared types and default widths.
// Imported by the FSM top and the wait-cycle counter.
package apb_pkg;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Bits needed to hold 0..limit; a zero limit still gets one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS wait-cycle counter.
// expired flags the wait cycle whose count reaches LIMIT.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int LIMIT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] TOP  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST =
    CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != TOP)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // LIMIT of zero disables the abort path entirely.
  assign expired = (LIMIT > 0) && enable
                && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester-side master: command in, one APB transfer,
// one-cycle response pulse with optional wait timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state_q;
  apb_state_e state_d;

  logic accept;
  logic in_access;
  logic wait_en;
  logic expired;
  logic done_ok;
  logic done_to;

  assign in_access = (state_q == ACCESS);
  assign accept    = cmd_valid && cmd_ready;
  assign wait_en   = in_access && !pready;
  assign done_ok   = in_access && pready;
  assign done_to   = wait_en && expired;

  // Bus strobes come straight from the state register.
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE):   cmd_ready = 1'b1;
      (state_q == SETUP):  psel      = 1'b1;
      (state_q == ACCESS): begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done_ok || done_to) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // Response fields hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done_ok || done_to;
      if (done_ok) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (done_to) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wait_en),
    .expired (expired)
  );

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master with a cycle-timeline model
// of each transfer and literal checks on directed transfers.
module tb_apb_master;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int NRND = 120;
  localparam int NTX  = 6 + NRND + 1 + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
    int          gap;
    bit          rst_mid;
  } txn_t;

  txn_t txns [NTX];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          obs_acc  [$];
  int          obs_rsp  [$];
  int          obs_psel [$];
  int          obs_pen  [$];
  logic [31:0] obs_rd   [$];
  bit          obs_err  [$];
  bit          obs_to   [$];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h",
                 name, cyc, got, exp);
    end
  endtask

  // Model: a transfer accepted in cycle a spends one SETUP cycle,
  // n ACCESS cycles, and pulses its response in cycle a+2+n.
  bit          act = 1'b0;
  int          a_c = 0;
  int          n_ac = 0;
  int          mdl_idx = 0;
  txn_t        m;
  bit          m_to;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_rd = '0;
  bit          e_write = 1'b0;
  bit          e_err = 1'b0;
  bit          e_to = 1'b0;
  bit          prev_psel = 1'b0;
  bit          prev_pen = 1'b0;

  always @(negedge clk) begin
    bit e_rv, e_ready, e_psel, e_pen;
    cyc++;
    e_rv = 1'b0;
    if (!rst) begin
      act = 1'b0;
      e_addr = '0; e_wdata = '0; e_write = 1'b0;
      e_rd = '0; e_err = 1'b0; e_to = 1'b0;
    end else if (act && (cyc - a_c) == 2 + n_ac) begin
      act   = 1'b0;
      e_rv  = 1'b1;
      e_to  = m_to;
      e_err = m_to ? 1'b1 : m.err;
      e_rd  = (m_to || m.write) ? 32'h0 : m.rdata;
    end
    e_psel  = act;
    e_pen   = act && (cyc - a_c) >= 2;
    e_ready = !act;

    chk("cmd_ready",   64'(cmd_ready),   64'(e_ready));
    chk("psel",        64'(psel),        64'(e_psel));
    chk("penable",     64'(penable),     64'(e_pen));
    chk("pwrite",      64'(pwrite),      64'(e_write));
    chk("paddr",       64'(paddr),       64'(e_addr));
    chk("pwdata",      64'(pwdata),      64'(e_wdata));
    chk("rsp_valid",   64'(rsp_valid),   64'(e_rv));
    chk("rsp_rdata",   64'(rsp_rdata),   64'(e_rd));
    chk("rsp_err",     64'(rsp_err),     64'(e_err));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));

    if (rst && cmd_valid && cmd_ready) obs_acc.push_back(cyc);
    if (psel && !prev_psel) obs_psel.push_back(cyc);
    if (penable && !prev_pen) obs_pen.push_back(cyc);
    if (rsp_valid) begin
      obs_rsp.push_back(cyc);
      obs_rd.push_back(rsp_rdata);
      obs_err.push_back(rsp_err);
      obs_to.push_back(rsp_timeout);
    end
    prev_psel = psel;
    prev_pen  = penable;

    if (rst && e_ready && cmd_valid && mdl_idx < NTX) begin
      act     = 1'b1;
      a_c     = cyc;
      m       = txns[mdl_idx];
      mdl_idx++;
      e_addr  = m.addr;
      e_wdata = m.wdata;
      e_write = m.write;
      m_to    = (TO > 0) && (m.waits >= TO);
      n_ac    = m_to ? TO : m.waits + 1;
    end
  end

  txn_t cur;
  int   pres;
  int   gap_left;
  int   k;
  bit   prev_acc;
  bit   rdy_prev;
  bit   inflight;
  bit   rst_hold;
  bit   done;

  initial begin
    txns[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 1'b0};
    txns[1] = '{1'b0, 32'h20, 32'h0, 32'h12345678, 3, 1'b0, 2, 1'b0};
    txns[2] = '{1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 0, 1'b1, 1, 1'b0};
    txns[3] = '{1'b0, 32'h28, 32'h0, 32'h0BADF00D, 9, 1'b0, 1, 1'b0};
    txns[4] = '{1'b1, 32'h30, 32'h55AA55AA, 32'h0, 0, 1'b0, 1, 1'b0};
    txns[5] = '{1'b0, 32'h34, 32'h0, 32'hCAFEF00D, 1, 1'b0, 0, 1'b0};
    for (int i = 6; i < NTX; i++) begin
      txns[i].write   = 1'($urandom_range(0, 1));
      txns[i].addr    = $urandom;
      txns[i].wdata   = $urandom;
      txns[i].rdata   = $urandom;
      txns[i].waits   = $urandom_range(0, 6);
      txns[i].err     = 1'($urandom_range(0, 1));
      txns[i].gap     = $urandom_range(0, 2);
      txns[i].rst_mid = 1'b0;
    end
    txns[6 + NRND].waits   = 10;
    txns[6 + NRND].rst_mid = 1'b1;

    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    pres = 0; gap_left = txns[0].gap; k = 0;
    prev_acc = 1'b0; rdy_prev = 1'b0; inflight = 1'b0;
    rst_hold = 1'b0; done = 1'b0;
    cur = txns[0];

    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (rst_hold) begin
        rst = 1'b1;
        rst_hold = 1'b0;
        #1 chk("ready_after_rst", 64'(cmd_ready), 64'd1);
      end
      if (cmd_valid && rdy_prev) begin
        cur = txns[pres];
        pres++;
        cmd_valid = 1'b0;
        inflight = 1'b1;
        if (pres < NTX) gap_left = txns[pres].gap;
      end
      if (rsp_valid) inflight = 1'b0;

      // Reactive slave; bus inputs are junk outside ACCESS.
      if (psel && penable) k = prev_acc ? k + 1 : 0;
      prev_acc = psel && penable;
      if (prev_acc && k == cur.waits) begin
        pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
      end else begin
        pready  = prev_acc ? 1'b0 : 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end

      if (prev_acc && cur.rst_mid && k == 1) begin
        #1 rst = 1'b0;
        #1;
        chk("rst_psel",    64'(psel),    64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        cmd_valid = 1'b0;
        inflight  = 1'b0;
        rst_hold  = 1'b1;
        prev_acc  = 1'b0;
      end

      if (rst && !cmd_valid && pres < NTX) begin
        if (gap_left > 0) begin
          gap_left--;
        end else begin
          cmd_valid = 1'b1;
          cmd_write = txns[pres].write;
          cmd_addr  = txns[pres].addr;
          cmd_wdata = txns[pres].wdata;
        end
      end
      rdy_prev = cmd_ready;
      done = (pres == NTX) && !inflight && !cmd_valid;
    end

    chk("run_completes", 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("acc_count", 64'(obs_acc.size()), 64'(NTX));
    chk("rsp_count", 64'(obs_rsp.size()), 64'(NTX - 1));
    if (obs_acc.size() >= 6 && obs_rsp.size() >= 6 &&
        obs_psel.size() >= 6 && obs_pen.size() >= 1) begin
      chk("wr_psel_lat", 64'(obs_psel[0] - obs_acc[0]), 64'd1);
      chk("wr_pen_lat",  64'(obs_pen[0] - obs_acc[0]),  64'd2);
      chk("wr_rsp_lat",  64'(obs_rsp[0] - obs_acc[0]),  64'd3);
      chk("wr_err",      64'(obs_err[0]), 64'd0);
      chk("wr_rdata",    64'(obs_rd[0]),  64'd0);
      chk("rd_wait_lat", 64'(obs_rsp[1] - obs_acc[1]), 64'd6);
      chk("rd_rdata",    64'(obs_rd[1]), 64'h12345678);
      chk("slverr_err",  64'(obs_err[2]), 64'd1);
      chk("slverr_to",   64'(obs_to[2]),  64'd0);
      chk("slverr_rd",   64'(obs_rd[2]),  64'hA5A5A5A5);
      chk("to_lat",      64'(obs_rsp[3] - obs_acc[3]), 64'd6);
      chk("to_err",      64'(obs_err[3]), 64'd1);
      chk("to_flag",     64'(obs_to[3]),  64'd1);
      chk("to_rdata",    64'(obs_rd[3]),  64'd0);
      chk("b2b_accept",  64'(obs_acc[5] - obs_rsp[4]), 64'd0);
      chk("b2b_gap",     64'(obs_psel[5] - obs_rsp[4]), 64'd1);
      chk("b2b_rdata",   64'(obs_rd[5]), 64'hCAFEF00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS wait cycles; 0 disables timeout.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  requester presents a transfer.
REQ-007 cmd_ready  output  1  master accepts a command this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  slave error or timeout, valid with rsp_valid.
REQ-014 rsp_timeout  output  1  completion was a timeout abort, valid with rsp_valid.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-017 prdata  input  DATA_W; pready  input  1; pslverr  input  1  APB slave response.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS held in one state register.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the edge where cmd_valid&&cmd_ready, moving IDLE->SETUP.
REQ-020 SHALL register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata on acceptance and hold them unchanged until the next acceptance.
REQ-021 SHALL drive psel=1 in SETUP and ACCESS, penable=1 only in ACCESS, both decoded directly from the state register.
REQ-022 SETUP SHALL last exactly one cycle, then ACCESS unconditionally.
REQ-023 In ACCESS with pready=1: next state IDLE; next cycle rsp_valid=1, rsp_err=pslverr, rsp_timeout=0, rsp_rdata=prdata for reads, 0 for writes.
REQ-024 In ACCESS with pready=0: remain in ACCESS, increment wait counter.
REQ-025 With TIMEOUT>0, when the wait counter reaches TIMEOUT with pready=0, SHALL abort to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 Wait counter SHALL clear on entry to SETUP, width clog2(TIMEOUT+1), never wrap.
REQ-027 Minimum latency: accept edge T; SETUP cycle T+1; ACCESS T+2; rsp_valid T+3 if pready at T+2.
REQ-028 rsp_valid SHALL be high for exactly one cycle per transfer; rsp_rdata/rsp_err/rsp_timeout hold last values otherwise.
REQ-029 A new command SHALL be accepted in the same cycle rsp_valid is high (back-to-back, one idle APB cycle between transfers).
REQ-030 pready/pslverr/prdata SHALL be ignored outside ACCESS.

Reset
REQ-031 On rst low, SHALL asynchronously force state IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pwdata, rsp_rdata = 0; counter = 0.
REQ-032 Reset mid-transfer SHALL drop psel/penable immediately and issue no response.

Structure
REQ-033 Shared package apb_pkg SHALL hold the state enum apb_state_e (IDLE, SETUP, ACCESS) and default width constants.
REQ-034 Timeout counter SHALL be sub-module apb_timeout_cnt (clear, enable, expired output).

Verification
REQ-035 Write addr 0x10, data 0xDEADBEEF, pready=1 at first ACCESS -> psel T+1, penable T+2, rsp_valid T+3, rsp_err=0.
REQ-036 Read addr 0x20, pready after 3 wait cycles, prdata 0x12345678 -> paddr stable throughout, rsp_rdata 0x12345678.
REQ-037 Read with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 Two back-to-back commands, cmd_valid held -> second accepted on first's rsp_valid cycle, psel low exactly one cycle between.
REQ-040 rst low during ACCESS -> psel/penable 0 same cycle, no rsp_valid, cmd_ready=1 after release.
